// File: rtl/gfx_pkg.sv
// Shared graphics constants for the VGA pixel path: colour format, key/background
// colours and the fixed layer index assignment used by the sprite generators.
package gfx_pkg;

  localparam int COLOR_W    = 12;
  localparam int GFX_LAYERS = 6;

  localparam logic [COLOR_W-1:0] BG_COLOR        = 12'h69C;
  localparam logic [COLOR_W-1:0] KEY_COLOR       = 12'h000;
  localparam logic [COLOR_W-1:0] HIGHLIGHT_COLOR = 12'hFFF;

  localparam int LAYER_WALL_U = 0;
  localparam int LAYER_WALL_D = 1;
  localparam int LAYER_WALL_L = 2;
  localparam int LAYER_WALL_R = 3;
  localparam int LAYER_ENEMY  = 4;
  localparam int LAYER_PLAYER = 5;

  typedef enum logic {
    MODE_PRIORITY  = 1'b0,
    MODE_HIGHLIGHT = 1'b1
  } comp_mode_e;

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel bus between the layer generators, the compositor and the VGA pins.
// master drives layers and syncs; slave is the compositor.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 6,
  parameter int COLOR_W    = 12
);
  logic                          bright_in;
  logic                          hsync_in;
  logic                          vsync_in;
  logic                          frame_start;
  logic                          mode;
  logic [NUM_LAYERS-1:0]         layer_en;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [COLOR_W-1:0]            rgb_out;
  logic                          hsync_out;
  logic                          vsync_out;
  logic [NUM_LAYERS-1:0]         collision_vec;
  logic                          collision_valid;

  modport master (
    output bright_in, hsync_in, vsync_in, frame_start, mode, layer_en, layer_rgb,
    input  rgb_out, hsync_out, vsync_out, collision_vec, collision_valid
  );

  modport slave (
    input  bright_in, hsync_in, vsync_in, frame_start, mode, layer_en, layer_rgb,
    output rgb_out, hsync_out, vsync_out, collision_vec, collision_valid
  );
endinterface

// File: rtl/layer_compositor_prio_select.sv
// Highest-index-wins colour selector over the visible layers; also flags
// whether any layer is visible at all.
module prio_select #(
  parameter int NUM_LAYERS = 6,
  parameter int COLOR_W    = 12
) (
  input  logic [NUM_LAYERS-1:0]              vis,
  input  logic [NUM_LAYERS-1:0][COLOR_W-1:0] rgb,
  output logic [COLOR_W-1:0]                 color,
  output logic                               any
);
  // Ascending scan so later (higher-index) hits overwrite lower ones.
  always_comb begin
    color = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (vis[i]) begin
        color = rgb[i];
        any   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/layer_compositor.sv
// Two-stage N-layer pixel compositor with transparency key, collision highlight
// and a per-frame collision vector against the player layer.
module layer_compositor #(
  parameter int                   NUM_LAYERS      = gfx_pkg::GFX_LAYERS,
  parameter int                   COLOR_W         = gfx_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0]   BG_COLOR        = gfx_pkg::BG_COLOR,
  parameter logic [COLOR_W-1:0]   KEY_COLOR       = gfx_pkg::KEY_COLOR,
  parameter logic [COLOR_W-1:0]   HIGHLIGHT_COLOR = gfx_pkg::HIGHLIGHT_COLOR,
  parameter int                   PLAYER_LAYER    = NUM_LAYERS - 1
) (
  input logic               clk,
  input logic               reset,
  layer_compositor_if.slave bus
);
  localparam logic [NUM_LAYERS-1:0] OTHER_MASK = ~(NUM_LAYERS'(1) << PLAYER_LAYER);

  logic [NUM_LAYERS-1:0]              vis;
  logic [NUM_LAYERS-1:0]              vis_s1;
  logic [NUM_LAYERS-1:0][COLOR_W-1:0] rgb_s1;
  logic                               bright_s1, hsync_s1, vsync_s1;
  gfx_pkg::comp_mode_e                mode_s1;
  logic [COLOR_W-1:0]                 sel_color;
  logic                               sel_any;
  logic                               overlap_s1;
  logic [NUM_LAYERS-1:0]              hit_s1;
  logic [NUM_LAYERS-1:0]              acc;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_vis
    assign vis[i] = bus.layer_en[i] && (bus.layer_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vis_s1    <= '0;
      rgb_s1    <= '0;
      bright_s1 <= 1'b0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      mode_s1   <= gfx_pkg::MODE_PRIORITY;
    end else begin
      vis_s1    <= vis;
      rgb_s1    <= bus.layer_rgb;
      bright_s1 <= bus.bright_in;
      hsync_s1  <= bus.hsync_in;
      vsync_s1  <= bus.vsync_in;
      mode_s1   <= gfx_pkg::comp_mode_e'(bus.mode);
    end
  end

  prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W)
  ) u_prio (
    .vis   (vis_s1),
    .rgb   (rgb_s1),
    .color (sel_color),
    .any   (sel_any)
  );

  assign overlap_s1 = vis_s1[PLAYER_LAYER] && (|(vis_s1 & OTHER_MASK));
  // Blanked pixels never register as collisions.
  assign hit_s1 = (bright_s1 && vis_s1[PLAYER_LAYER]) ? (vis_s1 & OTHER_MASK) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rgb_out   <= '0;
      bus.hsync_out <= 1'b1;
      bus.vsync_out <= 1'b1;
    end else begin
      bus.hsync_out <= hsync_s1;
      bus.vsync_out <= vsync_s1;
      if (!bright_s1)
        bus.rgb_out <= '0;
      else if (mode_s1 == gfx_pkg::MODE_HIGHLIGHT && overlap_s1)
        bus.rgb_out <= HIGHLIGHT_COLOR;
      else if (sel_any)
        bus.rgb_out <= sel_color;
      else
        bus.rgb_out <= BG_COLOR;
    end
  end

  // The hit landing on a frame_start cycle belongs to the frame being closed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc                 <= '0;
      bus.collision_vec   <= '0;
      bus.collision_valid <= 1'b0;
    end else begin
      bus.collision_valid <= bus.frame_start;
      if (bus.frame_start) begin
        bus.collision_vec <= acc | hit_s1;
        acc               <= '0;
      end else begin
        acc <= acc | hit_s1;
      end
    end
  end
endmodule

// File: tb/tb_layer_compositor.sv
// Randomised and directed bench for layer_compositor against a per-pixel
// behavioural model of priority, transparency and frame collision reporting.
module tb_layer_compositor;
  import gfx_pkg::*;

  localparam int NL = 6;
  localparam int CW = 12;

  typedef struct {
    logic          bright, hs, vs, fs, mode;
    logic [NL-1:0] en;
    logic [NL*CW-1:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus();

  layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  pix_t          prev;
  logic [NL-1:0] m_acc, m_vec;
  logic          m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pix_t zero_pix();
    pix_t p;
    p.bright = 0; p.hs = 0; p.vs = 0; p.fs = 0; p.mode = 0; p.en = '0; p.rgb = '0;
    return p;
  endfunction

  function automatic pix_t mkp(input logic b, input logic fs, input logic md,
                               input logic [NL-1:0] en, input logic [NL*CW-1:0] rgb);
    pix_t p;
    p.bright = b; p.hs = 1'b1; p.vs = 1'b1; p.fs = fs; p.mode = md; p.en = en; p.rgb = rgb;
    return p;
  endfunction

  function automatic logic [CW-1:0] slice(input pix_t p, input int i);
    logic [NL*CW-1:0] r;
    r = p.rgb;
    return r[i*CW +: CW];
  endfunction

  function automatic logic seen(input pix_t p, input int i);
    return p.en[i] && slice(p, i) != 12'h000;
  endfunction

  // Expected colour: look from the top layer down for the first visible one.
  function automatic logic [CW-1:0] ref_rgb(input pix_t p);
    int top;
    int others;
    top = -1;
    others = 0;
    for (int i = NL - 1; i >= 0; i--)
      if (seen(p, i)) begin
        if (top < 0) top = i;
        if (i != NL - 1) others++;
      end
    if (!p.bright) return 12'h000;
    if (p.mode && seen(p, NL - 1) && others > 0) return 12'hFFF;
    if (top >= 0) return slice(p, top);
    return 12'h69C;
  endfunction

  function automatic logic [NL-1:0] ref_hits(input pix_t p);
    logic [NL-1:0] h;
    h = '0;
    if (p.bright && seen(p, NL - 1))
      for (int i = 0; i < NL - 1; i++) h[i] = seen(p, i);
    return h;
  endfunction

  task automatic model_reset();
    prev = zero_pix();
    m_acc = '0;
    m_vec = '0;
    m_valid = 1'b0;
  endtask

  task automatic cyc(input pix_t p);
    logic [CW-1:0] e_rgb;
    logic          e_hs, e_vs;
    bus.bright_in   = p.bright;
    bus.hsync_in    = p.hs;
    bus.vsync_in    = p.vs;
    bus.frame_start = p.fs;
    bus.mode        = p.mode;
    bus.layer_en    = p.en;
    bus.layer_rgb   = p.rgb;
    @(posedge clk);
    #1;
    e_rgb = ref_rgb(prev);
    e_hs  = prev.hs;
    e_vs  = prev.vs;
    if (p.fs) begin
      m_vec   = m_acc | ref_hits(prev);
      m_acc   = '0;
      m_valid = 1'b1;
    end else begin
      m_acc   = m_acc | ref_hits(prev);
      m_valid = 1'b0;
    end
    prev = p;
    chk("rgb_out", 32'(bus.rgb_out), 32'(e_rgb));
    chk("hsync_out", 32'(bus.hsync_out), 32'(e_hs));
    chk("vsync_out", 32'(bus.vsync_out), 32'(e_vs));
    chk("collision_valid", 32'(bus.collision_valid), 32'(m_valid));
    chk("collision_vec", 32'(bus.collision_vec), 32'(m_vec));
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    logic [NL*CW-1:0] r;
    p.bright = ($urandom_range(7) != 0);
    p.hs     = 1'($urandom);
    p.vs     = 1'($urandom);
    p.fs     = ($urandom_range(39) == 0);
    p.mode   = 1'($urandom);
    p.en     = NL'($urandom);
    for (int i = 0; i < NL; i++)
      r[i*CW +: CW] = ($urandom_range(3) == 0) ? 12'h000 : CW'($urandom);
    p.rgb = r;
    return p;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"}, 32'(bus.rgb_out), 32'h000);
    chk({tag, "_hs"}, 32'(bus.hsync_out), 32'h1);
    chk({tag, "_vs"}, 32'(bus.vsync_out), 32'h1);
    chk({tag, "_vec"}, 32'(bus.collision_vec), 32'h0);
    chk({tag, "_valid"}, 32'(bus.collision_valid), 32'h0);
  endtask

  pix_t idle;

  initial begin
    idle = mkp(1'b1, 1'b0, 1'b0, '0, '0);
    reset = 1'b0;
    bus.bright_in = 0; bus.hsync_in = 0; bus.vsync_in = 0; bus.frame_start = 0;
    bus.mode = 0; bus.layer_en = '0; bus.layer_rgb = '0;
    model_reset();
    #13;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;

    // Priority: layer 2 over layer 0, then nothing visible.
    cyc(mkp(1, 0, 0, 6'b000101, {12'h0, 12'h0, 12'h0, 12'hF00, 12'h0, 12'h0F0}));
    cyc(mkp(1, 0, 0, 6'b000000, {12'h0, 12'h0, 12'h0, 12'hF00, 12'h0, 12'h0F0}));
    chk("prio_l2", 32'(bus.rgb_out), 32'hF00);
    cyc(idle);
    chk("bg", 32'(bus.rgb_out), 32'h69C);

    // Keyed player over layer 1: transparent and no collision.
    cyc(mkp(1, 1, 0, '0, '0));
    cyc(mkp(1, 0, 1, 6'b100010, {12'h000, 12'h0, 12'h0, 12'h0, 12'h123, 12'h0}));
    cyc(mkp(1, 1, 0, '0, '0));
    chk("key_rgb", 32'(bus.rgb_out), 32'h123);
    chk("key_nocoll", 32'(bus.collision_vec), 32'h0);

    // Highlight vs strict priority on the same overlap.
    cyc(mkp(1, 0, 1, 6'b100100, {12'hABC, 12'h0, 12'h0, 12'hF00, 12'h0, 12'h0}));
    cyc(mkp(1, 0, 0, 6'b100100, {12'hABC, 12'h0, 12'h0, 12'hF00, 12'h0, 12'h0}));
    chk("highlight", 32'(bus.rgb_out), 32'hFFF);
    cyc(idle);
    chk("strict", 32'(bus.rgb_out), 32'hABC);

    // Frame with overlaps on layers 2 and 0 on separate pixels.
    cyc(mkp(1, 1, 0, '0, '0));
    cyc(mkp(1, 0, 0, 6'b100100, {12'hABC, 12'h0, 12'h0, 12'hF00, 12'h0, 12'h0}));
    cyc(mkp(1, 0, 0, 6'b100001, {12'hABC, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0F0}));
    cyc(idle);
    cyc(mkp(1, 1, 0, '0, '0));
    chk("frame_valid", 32'(bus.collision_valid), 32'h1);
    chk("frame_vec", 32'(bus.collision_vec), 32'h05);
    cyc(idle);
    chk("valid_pulse", 32'(bus.collision_valid), 32'h0);
    chk("vec_hold", 32'(bus.collision_vec), 32'h05);
    cyc(idle);
    cyc(mkp(1, 1, 0, '0, '0));
    chk("empty_frame", 32'(bus.collision_vec), 32'h0);

    // Blanked overlap ignored; overlap coincident with frame_start credited.
    cyc(mkp(0, 0, 0, 6'b111111, {6{12'h111}}));
    cyc(mkp(1, 0, 0, 6'b100010, {12'hABC, 12'h0, 12'h0, 12'h0, 12'h222, 12'h0}));
    cyc(mkp(1, 1, 0, '0, '0));
    chk("coincident", 32'(bus.collision_vec), 32'h02);
    cyc(mkp(1, 1, 0, '0, '0));
    chk("b2b_valid", 32'(bus.collision_valid), 32'h1);
    chk("b2b_vec", 32'(bus.collision_vec), 32'h0);

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        // Asynchronous reset in the middle of a frame.
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cyc(mkp(1, 0, 0, 6'b010000, {12'h0, 12'h456, 12'h0, 12'h0, 12'h0, 12'h0}));
        chk("rel_first", 32'(bus.rgb_out), 32'h000);
        cyc(idle);
        chk("rel_pixel", 32'(bus.rgb_out), 32'h456);
      end
      cyc(rand_pix());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
